// File: rtl/mod_n_counter_chain_pkg.sv
// Shared constants and helpers for the mod-N counter chain.
package counter_pkg;
   localparam int DEFAULT_BASE   = 10;
   localparam int DEFAULT_DIGITS = 4;
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Bits needed to hold one digit of the given modulus (BASE in 2..16).
   function automatic int digit_width(input int base);
      digit_width = 1;
      for (int k = 1; k < 5; k++)
         if ((1 << k) < base) digit_width = k + 1;
   endfunction
endpackage

// File: rtl/mod_n_counter_chain_if.sv
// Control/data bundle for mod_n_counter_chain; counter side is the slave.
interface mod_n_counter_chain_if
   import counter_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int BASE   = DEFAULT_BASE
);
   localparam int W = digit_width(BASE);

   logic                  en;
   logic                  up;
   logic                  load;
   logic [DIGITS*W-1:0]   load_val;
   logic [DIGITS*W-1:0]   count;
   logic                  tc;
   logic                  ovf;

   modport master (output en, up, load, load_val, input count, tc, ovf);
   modport slave  (input en, up, load, load_val, output count, tc, ovf);
endinterface

// File: rtl/mod_n_counter_chain_digit.sv
// One modulo-BASE digit: load with sanitising, up/down step, terminal detect.
module mod_n_digit
   import counter_pkg::*;
#(
   parameter int BASE = DEFAULT_BASE,
   localparam int W   = digit_width(BASE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step_in,
   input  logic         up,
   input  logic         load,
   input  logic [W-1:0] load_d,
   output logic [W-1:0] q,
   output logic         term
);
   localparam logic [W-1:0] MAXV = W'(BASE - 1);

   logic [W-1:0] nxt;
   logic         bad;

   assign term = (up == DIR_UP) ? (q == MAXV) : (q == '0);
   // Wrap is decoded from term, never from a 2^W rollover.
   assign nxt  = (up == DIR_UP) ? (term ? '0 : q + W'(1))
                                : (term ? MAXV : q - W'(1));
   assign bad  = {1'b0, load_d} >= (W+1)'(BASE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          q <= '0;
      else if (load)    q <= bad ? '0 : load_d;
      else if (step_in) q <= nxt;
   end
endmodule

// File: rtl/mod_n_counter_chain.sv
// Cascaded modulo-BASE up/down counter with load, tc and ovf.
// Optional COUNTER_SATURATE_EN: hold at the limit instead of wrapping.
module mod_n_counter_chain
   import counter_pkg::*;
#(
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int BASE   = DEFAULT_BASE,
   localparam int W     = digit_width(BASE)
) (
   input  logic                  clk,
   input  logic                  rst,
   mod_n_counter_chain_if.slave  bus
);
   logic [DIGITS-1:0][W-1:0] cnt;
   logic [DIGITS-1:0]        term;
   logic [DIGITS:0]          carry;
   logic                     ovf_q;

   assign bus.tc = bus.en & (&term);

`ifdef COUNTER_SATURATE_EN
   assign carry[0] = bus.en & ~(&term);
`else
   assign carry[0] = bus.en;
`endif

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_dig
         assign carry[i+1] = carry[i] & term[i];
         mod_n_digit #(.BASE(BASE)) u_dig (
            .clk     (clk),
            .rst     (rst),
            .step_in (carry[i]),
            .up      (bus.up),
            .load    (bus.load),
            .load_d  (bus.load_val[i*W +: W]),
            .q       (cnt[i]),
            .term    (term[i])
         );
      end
   endgenerate

   // Same expression for both builds: a wrap, or a blocked step at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= bus.tc & ~bus.load;
   end

   assign bus.count = cnt;
   assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mod_n_counter_chain.sv
// Directed bench: 4x base-10 chain plus 2x base-6 chain.
module tb_mod_n_counter_chain;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   mod_n_counter_chain_if #(.DIGITS(4), .BASE(10)) ia ();
   mod_n_counter_chain_if #(.DIGITS(2), .BASE(6))  ib ();

   mod_n_counter_chain #(.DIGITS(4), .BASE(10)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   mod_n_counter_chain #(.DIGITS(2), .BASE(6))  dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lda(input logic [15:0] v);
      ia.load = 1'b1; ia.load_val = v;
      tick();
      ia.load = 1'b0;
   endtask

   int pulses;

   initial begin
      ia.en = 0; ia.up = 1; ia.load = 0; ia.load_val = '0;
      ib.en = 0; ib.up = 1; ib.load = 0; ib.load_val = '0;
      #12;
      chk("rst_count", ia.count, 16'h0000);
      chk("rst_ovf", ia.ovf, 0);
      rst = 0;
      tick();

      // reset mid-count
      ia.en = 1;
      lda(16'h0536);
      chk("ld_0536", ia.count, 16'h0536);
      tick();
      chk("cnt_0537", ia.count, 16'h0537);
      rst = 1; #2;
      chk("async_rst_cnt", ia.count, 16'h0000);
      chk("async_rst_ovf", ia.ovf, 0);
      rst = 0;
      tick();
      chk("resume_0001", ia.count, 16'h0001);

      // up wrap
      lda(16'h9998);
      chk("ld_9998", ia.count, 16'h9998);
      chk("ld_ovf0", ia.ovf, 0);
      tick();
      chk("up_9999", ia.count, 16'h9999);
      chk("up_tc", ia.tc, 1);
      tick();
`ifdef COUNTER_SATURATE_EN
      chk("sat_hold1", ia.count, 16'h9999);
      chk("sat_ovf1", ia.ovf, 1);
      tick();
      chk("sat_hold2", ia.count, 16'h9999);
      chk("sat_ovf2", ia.ovf, 1);
      ia.up = 0;
      chk("sat_tc_dn", ia.tc, 0);
      tick();
      chk("sat_back", ia.count, 16'h9998);
      chk("sat_back_ovf", ia.ovf, 0);
`else
      chk("wrap_0000", ia.count, 16'h0000);
      chk("wrap_ovf", ia.ovf, 1);
      tick();
      chk("wrap_0001", ia.count, 16'h0001);
      chk("wrap_ovf_clr", ia.ovf, 0);
`endif

      // down wrap and borrows
      ia.up = 0;
      lda(16'h0000);
      chk("dn_tc", ia.tc, 1);
      tick();
`ifdef COUNTER_SATURATE_EN
      chk("sat_dn_hold", ia.count, 16'h0000);
`else
      chk("dn_wrap", ia.count, 16'h9999);
`endif
      chk("dn_ovf", ia.ovf, 1);
      lda(16'h0100);
      tick();
      chk("dn_0099", ia.count, 16'h0099);
      lda(16'h1000);
      tick();
      chk("dn_0999", ia.count, 16'h0999);
      chk("dn_ovf0", ia.ovf, 0);

      // load priority over en, digit 12 sanitised to 0
      ia.up = 1;
      lda(16'h1C34);
      chk("ld_sanitise", ia.count, 16'h1034);
      chk("ld_sanit_ovf", ia.ovf, 0);
      ia.en = 0;
      tick();
      chk("hold_cnt", ia.count, 16'h1034);
      chk("hold_ovf", ia.ovf, 0);
      chk("hold_tc", ia.tc, 0);

      // base 6, two digits: 3 bits per digit, so "10" reads as 6'o10
      pulses = 0;
      ib.en = 1;
      for (int s = 1; s <= 37; s++) begin
         tick();
         if (s <= 36 && ib.ovf) pulses++;
         if (s == 5)  chk("b6_05", ib.count, 6'o05);
         if (s == 6)  chk("b6_10", ib.count, 6'o10);
         if (s == 35) chk("b6_55", ib.count, 6'o55);
`ifdef COUNTER_SATURATE_EN
         if (s == 36) chk("b6_sat36", ib.count, 6'o55);
         if (s == 37) chk("b6_sat_ovf", ib.ovf, 1);
`else
         if (s == 36) chk("b6_wrap", ib.count, 6'o00);
         if (s == 37) chk("b6_01", ib.count, 6'o01);
         if (s == 37) chk("b6_ovf_clr", ib.ovf, 0);
`endif
      end
      chk("b6_pulses", pulses, 1);
      ib.en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
